// File: rtl/uart_hex_streamer.sv
// UART transmitter that prints one captured DATA_W-bit word as ASCII hex,
// with optional "0x" prefix, digit-group separators and LF/CRLF terminator.
module uart_hex_streamer #(
  parameter int unsigned   DATA_W    = 512,
  parameter int unsigned   BAUD_DIV  = 104,
  parameter int unsigned   STOP_BITS = 1,
  parameter int unsigned   UPPERCASE = 0,
  parameter int unsigned   PREFIX_0X = 0,
  parameter int unsigned   GROUP     = 0,
  parameter logic [7:0]    SEP_CHAR  = 8'h20,
  parameter int unsigned   TERM      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       char_cnt
);

  localparam int unsigned N     = DATA_W / 4;
  localparam int unsigned BW    = $clog2(BAUD_DIV);
  localparam int unsigned DW    = $clog2(N + 1);
  localparam int unsigned GW    = (GROUP > 0) ? $clog2(GROUP + 1) : 1;
  localparam int unsigned GLAST = (GROUP > 0) ? GROUP - 1 : 0;
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [2:0] {PH_PFX0, PH_PFX1, PH_DIG, PH_SEP, PH_CR, PH_LF, PH_END} phase_t;

  localparam phase_t FIRST_PH = (PREFIX_0X != 0) ? PH_PFX0 : PH_DIG;
  localparam phase_t TERM_PH  = (TERM == 2) ? PH_CR : (TERM == 1) ? PH_LF : PH_END;

  state_t            state, state_next;
  logic [BW-1:0]     baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic              stop_idx, stop_next;
  logic              tx_next;
  logic              load, advance, finish, stop_entry;
  logic              baud_end;

  phase_t            phase, phase_adv;
  logic [DW-1:0]     digit_idx, digit_adv;
  logic [GW-1:0]     grp_cnt, grp_adv;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        nib;
  logic [7:0]        hex_char, cur_char;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign baud_end = (baud_cnt == BW'(BAUD_DIV - 1));

  // Character currently on the wire comes only from registered sequencer state.
  always_comb begin
    nib = shreg[DATA_W-1 -: 4];
    if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
    else             hex_char = ((UPPERCASE != 0) ? 8'h37 : 8'h57) + {4'h0, nib};
    case (phase)
      PH_PFX0: cur_char = 8'h30;
      PH_PFX1: cur_char = 8'h78;
      PH_DIG:  cur_char = hex_char;
      PH_SEP:  cur_char = SEP_CHAR;
      PH_CR:   cur_char = 8'h0D;
      PH_LF:   cur_char = 8'h0A;
      default: cur_char = 8'hFF;
    endcase
  end

  always_comb begin
    phase_adv = phase;
    digit_adv = digit_idx;
    grp_adv   = grp_cnt;
    case (phase)
      PH_PFX0: phase_adv = PH_PFX1;
      PH_PFX1: phase_adv = PH_DIG;
      PH_DIG: begin
        digit_adv = digit_idx + DW'(1);
        // Terminator check precedes grouping so no separator trails the last digit.
        if (digit_idx == DW'(N - 1)) begin
          phase_adv = TERM_PH;
        end else if ((GROUP > 0) && (grp_cnt == GW'(GLAST))) begin
          phase_adv = PH_SEP;
          grp_adv   = '0;
        end else begin
          grp_adv = grp_cnt + GW'(1);
        end
      end
      PH_SEP:  phase_adv = PH_DIG;
      PH_CR:   phase_adv = PH_LF;
      PH_LF:   phase_adv = PH_END;
      default: phase_adv = PH_END;
    endcase
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    stop_next  = stop_idx;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    stop_entry = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = START;
          baud_next  = '0;
          load       = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            stop_next  = 1'b0;
            stop_entry = 1'b1;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (stop_idx == STOP_LAST) begin
            advance = 1'b1;
            if (phase_adv == PH_END) begin
              state_next = IDLE;
              finish     = 1'b1;
            end else begin
              state_next = START;
            end
          end else begin
            stop_next = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_char[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      tx        <= 1'b1;
      done      <= 1'b0;
      char_cnt  <= '0;
      phase     <= PH_END;
      digit_idx <= '0;
      grp_cnt   <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      stop_idx <= stop_next;
      tx       <= tx_next;
      done     <= finish;
      if (load)
        char_cnt <= '0;
      else if (stop_entry && (char_cnt != '1))
        char_cnt <= char_cnt + 16'd1;
      if (load) begin
        phase     <= FIRST_PH;
        digit_idx <= '0;
        grp_cnt   <= '0;
      end else if (advance) begin
        phase     <= phase_adv;
        digit_idx <= digit_adv;
        grp_cnt   <= grp_adv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      shreg <= in_data;
    else if (advance && (phase == PH_DIG))
      shreg <= shreg << 4;
  end

endmodule
